// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP / OP-IMM issue stage with a two-entry skid buffer.
// Decodes funct3/bit30 into a 4-bit ALU opcode, selects operands and hands
// them to the ALU through a registered main slot backed by one skid slot.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. valid, once raised, stays high with
// all payload fields stable until the transfer completes. ready_o is a flop
// and never depends combinationally on ready_in or valid_in.
module alu_issue_stage (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic        valid_in,
    output logic        ready_o,
    input  logic [2:0]  funct3_in,
    input  logic        funct7_5_in,
    input  logic        is_imm_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  rd_in,
    output logic        valid_o,
    input  logic        ready_in,
    output logic [31:0] op_1_o,
    output logic [31:0] op_2_o,
    output logic [3:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [15:0] issued_count_o
);

    typedef struct packed {
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [3:0]  opcode;
        logic [4:0]  rd;
    } entry_t;

    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        ready_q, ready_d;
    logic [15:0] count_q, count_d;

    entry_t      in_entry;
    logic        alt;
    logic        is_shift;
    logic [31:0] op_2_src;
    logic        accept;
    logic        out_hs;

    // Decode the incoming operation into an ALU entry.
    always_comb begin
        is_shift = (funct3_in == 3'b001) || (funct3_in == 3'b101);
        // bit30 selects SRA in both forms, but SUB only in the register form:
        // ADDI has no subtract variant, so bit30 of an immediate is ignored.
        if (funct3_in == 3'b101)
            alt = funct7_5_in;
        else if ((funct3_in == 3'b000) && !is_imm_in)
            alt = funct7_5_in;
        else
            alt = 1'b0;
        op_2_src        = is_imm_in ? imm_in : rs2_data_in;
        in_entry.op_1   = rs1_data_in;
        in_entry.op_2   = is_shift ? {27'b0, op_2_src[4:0]} : op_2_src;
        in_entry.opcode = {alt, funct3_in};
        in_entry.rd     = rd_in;
    end

    assign accept = valid_in && ready_q && !flush_in;
    assign out_hs = main_valid_q && ready_in;

    // Next-state for main/skid slots, ready flop and issue counter.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        count_d      = count_q + {15'b0, out_hs};
        if (!main_valid_q || out_hs) begin
            // Main is free this edge: oldest waiting entry moves in first.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the accepted entry in the skid slot.
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        if (flush_in) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
        ready_d = !skid_valid_d;
    end

    // State registers; reset wins over flush and both handshakes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            count_q      <= 16'h0000;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            count_q      <= count_d;
        end
    end

    assign ready_o        = ready_q;
    assign valid_o        = main_valid_q;
    assign op_1_o         = main_q.op_1;
    assign op_2_o         = main_q.op_2;
    assign opcode_o       = main_q.opcode;
    assign rd_o           = main_q.rd;
    assign issued_count_o = count_q;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 flush_in  input  1  synchronous discard of all held and incoming operations.
REQ-005 valid_in  input  1  upstream decode presents an operation.
REQ-006 ready_o  output  1  stage can accept an operation this cycle.
REQ-007 funct3_in  input  3  RV32I funct3 of the operation.
REQ-008 funct7_5_in  input  1  instruction bit 30 (alternate-op bit).
REQ-009 is_imm_in  input  1  1 = OP-IMM form (use imm_in), 0 = OP form (use rs2_data_in).
REQ-010 rs1_data_in, rs2_data_in, imm_in  input  32 each  operand sources; imm_in already sign-extended.
REQ-011 rd_in  input  5  destination register tag, passed through.
REQ-012 valid_o  output  1  op_1_o/op_2_o/opcode_o/rd_o hold a valid operation.
REQ-013 ready_in  input  1  downstream ALU/writeback consumes the operation.
REQ-014 op_1_o, op_2_o  output  32 each  ALU operands.
REQ-015 opcode_o  output  4  ALU opcode, encoding per REQ-020.
REQ-016 rd_o  output  5  destination tag matching the operation.
REQ-017 issued_count_o  output  16  count of completed output handshakes.

Function
REQ-018 Input handshake: operation accepted iff valid_in && ready_o at a rising edge; output handshake completes iff valid_o && ready_in.
REQ-019 Storage: one output register (main) plus one skid register; ready_o SHALL be a registered signal equal to NOT skid-valid; no combinational path from ready_in to ready_o.
REQ-020 Opcode = {alt, funct3_in}: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
REQ-021 alt: OP form -- alt = funct7_5_in when funct3 is 000 or 101, else 0; OP-IMM form -- alt = funct7_5_in when funct3 is 101, else 0 (ADDI never yields SUB).
REQ-022 op_1_o = rs1_data_in; op_2_o = is_imm_in ? imm_in : rs2_data_in.
REQ-023 Shifts (funct3 001 or 101): op_2_o SHALL be the selected source masked to bits [4:0], bits [31:5] zero.
REQ-024 Latency: accepted operation SHALL appear on valid_o the next cycle when main is empty or draining; throughput one operation per cycle with ready_in held high.
REQ-025 Main load: when main empty or output handshake completes, main loads skid if skid valid, else the accepted input, else becomes empty.
REQ-026 Skid load: accepted input while main full and ready_in low SHALL go to skid; ready_o deasserts the following cycle.
REQ-027 Ordering: operations SHALL leave in acceptance order; none dropped or duplicated except by flush/reset.
REQ-028 Outputs SHALL be stable (all fields) while valid_o && !ready_in.
REQ-029 flush_in: next cycle main and skid empty, valid_o 0, ready_o 1; an input offered in the flush cycle SHALL be discarded; an output handshake in the flush cycle SHALL still count.
REQ-030 issued_count_o increments by 1 per output handshake, wraps 0xFFFF -> 0x0000; unaffected by flush.
REQ-031 Invalid-slot datapath values are don't-care but SHALL not be X-propagated into valid_o.

Reset
REQ-032 rst_in high at a rising edge: valid_o 0, ready_o 1, skid empty, issued_count_o 0, op_1_o/op_2_o 0, opcode_o 0000, rd_o 0.
REQ-033 Reset SHALL take priority over flush_in and all handshakes; an operation held mid-stall is discarded.

Verification
REQ-034 Reset: rst_in=1 one cycle -> valid_o=0, ready_o=1, issued_count_o=0, opcode_o=0000.
REQ-035 SUB: OP, funct3=000, funct7_5=1, rs1=10, rs2=3, rd=5, ready_in=1 -> next cycle valid_o=1, opcode_o=1000, op_1_o=10, op_2_o=3, rd_o=5, count=1 after handshake.
REQ-036 ADDI with bit30 set: OP-IMM, funct3=000, funct7_5=1, imm=0xFFFFFFFF -> opcode_o=0000, op_2_o=0xFFFFFFFF.
REQ-037 SRAI: OP-IMM, funct3=101, funct7_5=1, imm=0x0000041F -> opcode_o=1101, op_2_o=0x0000001F.
REQ-038 Backpressure: ready_in=0, offer A,B,C on consecutive cycles -> A,B accepted, ready_o=0 before C, C held upstream; ready_in=1 -> A,B,C emerge in order on consecutive cycles, count +3.
REQ-039 Flush: main and skid full, flush_in=1 with valid_in=1 -> next cycle valid_o=0, ready_o=1, incoming discarded, issued_count_o unchanged.
